// File: rtl/motor_pwm_driver_pkg.sv
// motor_pwm_driver_pkg: shared FSM states, speed width and default timing constants.
package motor_pwm_driver_pkg;
  localparam int SPD_W            = 14;
  localparam int PWM_PERIOD_DEF   = 12500;
  localparam int DEAD_PERIODS_DEF = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DEAD} state_t;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one H-bridge channel -- boundary-sampled shadows, IDLE/RUN/DEAD FSM,
// dead-time period counting and registered, mutually exclusive bridge outputs.
module pwm_channel
  import motor_pwm_driver_pkg::*;
#(
  parameter int DEAD_PERIODS = DEAD_PERIODS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_last,
  input  logic [SPD_W-1:0] i_cnt,
  input  logic [SPD_W-1:0] i_speed,
  input  logic             i_dir,
  output logic             o_in1,
  output logic             o_in2
);
  state_t           r_state, w_next;
  logic [SPD_W-1:0] r_spd;
  logic             r_dir;
  logic [7:0]       r_dcnt;
  logic             w_dead_done, w_pwm, w_in1, w_in2;

  assign w_dead_done = r_dcnt == 8'(DEAD_PERIODS - 1);
  // cnt never reaches PWM_PERIOD, so comparing against the raw shadow equals min(speed, PWM_PERIOD)
  assign w_pwm       = i_cnt < r_spd;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (i_last)
      case (r_state)
        ST_IDLE: w_next = i_speed != '0 ? ST_RUN : ST_IDLE;
        ST_RUN:  w_next = i_speed == '0 ? ST_IDLE : (i_dir != r_dir ? ST_DEAD : ST_RUN);
        ST_DEAD: w_next = !w_dead_done ? ST_DEAD : (i_speed == '0 ? ST_IDLE : ST_RUN);
        default: w_next = ST_IDLE;
      endcase
  end

  // in RUN the shadow dir always equals the active dir, any mismatch having already forced DEAD
  always_comb begin
    w_in1 = i_en && r_state == ST_RUN && r_dir && w_pwm;
    w_in2 = i_en && r_state == ST_RUN && !r_dir && w_pwm;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_spd  <= '0;
      r_dir  <= 1'b1;
      r_dcnt <= '0;
    end else if (i_last) begin
      r_spd  <= i_speed;
      r_dir  <= i_dir;
      r_dcnt <= r_state == ST_DEAD ? r_dcnt + 8'd1 : 8'd0;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_in1 <= 1'b0;
      o_in2 <= 1'b0;
    end else begin
      o_in1 <= w_in1;
      o_in2 <= w_in2;
    end
endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: dual-channel H-bridge PWM driver with a shared period counter
// and a synchronised node-edge counter.
module motor_pwm_driver
  import motor_pwm_driver_pkg::*;
#(
  parameter int PWM_PERIOD   = PWM_PERIOD_DEF,
  parameter int DEAD_PERIODS = DEAD_PERIODS_DEF
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             enable,
  input  logic [SPD_W-1:0] speed_l,
  input  logic [SPD_W-1:0] speed_r,
  input  logic             dir_l,
  input  logic             dir_r,
  input  logic             node,
  output logic             l_in1,
  output logic             l_in2,
  output logic             r_in1,
  output logic             r_in2,
  output logic [7:0]       node_count,
  output logic             period_start
);
  logic [SPD_W-1:0] r_cnt;
  logic             r_s1, r_s2, r_s3;
  logic             w_last;

  assign w_last       = r_cnt == SPD_W'(PWM_PERIOD - 1);
  assign period_start = rst && r_cnt == '0;

  always_ff @(posedge clk_50M or negedge rst)
    if (!rst) r_cnt <= '0;
    else      r_cnt <= w_last ? '0 : r_cnt + 14'd1;

  // r_s1/r_s2 synchronise node; r_s3 holds the previous synchronised level for edge detection
  always_ff @(posedge clk_50M or negedge rst)
    if (!rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      node_count <= '0;
    end else begin
      r_s1 <= node;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (r_s2 && !r_s3) node_count <= node_count + 8'd1;
    end

  pwm_channel #(.DEAD_PERIODS(DEAD_PERIODS)) u_l (
    .clk(clk_50M), .rst_n(rst), .i_en(enable), .i_last(w_last), .i_cnt(r_cnt),
    .i_speed(speed_l), .i_dir(dir_l), .o_in1(l_in1), .o_in2(l_in2)
  );

  pwm_channel #(.DEAD_PERIODS(DEAD_PERIODS)) u_r (
    .clk(clk_50M), .rst_n(rst), .i_en(enable), .i_last(w_last), .i_cnt(r_cnt),
    .i_speed(speed_r), .i_dir(dir_r), .o_in1(r_in1), .o_in2(r_in2)
  );
endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver: directed checks of the PWM driver with a shortened 1250-cycle period
// (speeds scaled by 1/10) so the whole run stays small.
module tb_motor_pwm_driver;
  import motor_pwm_driver_pkg::*;
  localparam int P = 1250;
  logic        clk_50M = 1'b0, rst = 1'b0, enable = 1'b0;
  logic        dir_l = 1'b1, dir_r = 1'b1, node = 1'b0;
  logic [13:0] speed_l = '0, speed_r = '0;
  logic        l_in1, l_in2, r_in1, r_in2, period_start;
  logic [7:0]  node_count;
  int          total = 0, bad = 0;
  int          h_l1, h_l2, h_r1, h_r2, ov;

  always #5 clk_50M = ~clk_50M;

  motor_pwm_driver #(.PWM_PERIOD(P), .DEAD_PERIODS(2)) dut (
    .clk_50M(clk_50M), .rst(rst), .enable(enable), .speed_l(speed_l), .speed_r(speed_r),
    .dir_l(dir_l), .dir_r(dir_r), .node(node), .l_in1(l_in1), .l_in2(l_in2),
    .r_in1(r_in1), .r_in2(r_in2), .node_count(node_count), .period_start(period_start)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    h_l1 = 0; h_l2 = 0; h_r1 = 0; h_r2 = 0; ov = 0;
  endtask

  task automatic count_win(input int n);
    for (int i = 0; i < n; i++) begin
      h_l1 += int'(l_in1);
      h_l2 += int'(l_in2);
      h_r1 += int'(r_in1);
      h_r2 += int'(r_in2);
      ov   += int'(l_in1 & l_in2) + int'(r_in1 & r_in2);
      @(negedge clk_50M);
    end
  endtask

  task automatic chk_win(input string tag, input int e_l1, input int e_l2, input int e_r1, input int e_r2);
    chk({tag, "_l1"}, h_l1, e_l1);
    chk({tag, "_l2"}, h_l2, e_l2);
    chk({tag, "_r1"}, h_r1, e_r1);
    chk({tag, "_r2"}, h_r2, e_r2);
    chk({tag, "_overlap"}, ov, 0);
  endtask

  task automatic win(input string tag, input int e_l1, input int e_l2, input int e_r1, input int e_r2);
    chk({tag, "_ps"}, int'(period_start), 1);
    clr();
    count_win(P);
    chk_win(tag, e_l1, e_l2, e_r1, e_r2);
  endtask

  task automatic wait_ps();
    int n = 0;
    while (!period_start && n < 2 * P) begin
      @(negedge clk_50M);
      n++;
    end
    chk("wait_ps", int'(period_start), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk_50M);
    chk("rst_out", int'({l_in1, l_in2, r_in1, r_in2}), 0);
    chk("rst_node", int'(node_count), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_lst", int'(dut.u_l.r_state), int'(ST_IDLE));
    chk("rst_rst", int'(dut.u_r.r_state), int'(ST_IDLE));
    rst = 1'b1;
    #1 chk("start_ps", int'(period_start), 1);
    @(negedge clk_50M);
    enable = 1'b1; speed_l = 14'd1100; dir_l = 1'b1;
    clr();
    count_win(P - 1);
    chk_win("w0", 0, 0, 0, 0);
    speed_r = 14'd16000;
    win("w1", 1100, 0, 0, 0);
    win("w2", 1100, 0, 1249, 0);
    speed_r = 14'd0;
    win("w3", 1100, 0, 1250, 0);
    dir_l = 1'b0;
    win("w4", 1100, 0, 1, 0);
    chk("w4_r_idle", int'(dut.u_r.r_state), int'(ST_IDLE));
    chk("w5_ps", int'(period_start), 1);
    clr();
    count_win(600);
    chk("w5_dead", int'(dut.u_l.r_state), int'(ST_DEAD));
    dir_l = 1'b1;
    count_win(650);
    chk_win("w5", 0, 0, 0, 0);
    chk("w6_ps", int'(period_start), 1);
    clr();
    count_win(600);
    dir_l = 1'b0;
    count_win(650);
    chk_win("w6", 0, 0, 0, 0);
    chk("w7_ps", int'(period_start), 1);
    clr();
    count_win(300);
    speed_l = 14'd500;
    count_win(950);
    chk_win("w7", 0, 1100, 0, 0);
    win("w8", 0, 500, 0, 0);
    enable = 1'b0;
    win("w9", 0, 0, 0, 0);
    enable = 1'b1;
    win("w10", 0, 500, 0, 0);
    for (int i = 0; i < 258; i++) begin
      node = 1'b1;
      repeat (2) @(negedge clk_50M);
      node = 1'b0;
      repeat (2) @(negedge clk_50M);
    end
    repeat (4) @(negedge clk_50M);
    chk("node_258", int'(node_count), 2);
    node = 1'b1;
    repeat (100) @(negedge clk_50M);
    node = 1'b0;
    repeat (4) @(negedge clk_50M);
    chk("node_hold", int'(node_count), 3);
    wait_ps();
    dir_l = 1'b1; speed_r = 14'd1600; dir_r = 1'b1;
    win("w11", 0, 500, 0, 0);
    chk("w12_ps", int'(period_start), 1);
    clr();
    count_win(600);
    chk_win("w12", 0, 0, 599, 0);
    chk("w12_dead", int'(dut.u_l.r_state), int'(ST_DEAD));
    enable = 1'b0;
    @(negedge clk_50M);
    chk("en_off", int'(r_in1), 0);
    enable = 1'b1;
    @(negedge clk_50M);
    chk("en_on", int'(r_in1), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_out", int'({l_in1, l_in2, r_in1, r_in2}), 0);
    chk("arst_node", int'(node_count), 0);
    chk("arst_ps", int'(period_start), 0);
    chk("arst_lst", int'(dut.u_l.r_state), int'(ST_IDLE));
    chk("arst_rst", int'(dut.u_r.r_state), int'(ST_IDLE));
    repeat (2) @(negedge clk_50M);
    rst = 1'b1;
    #1 chk("rel_ps", int'(period_start), 1);
    chk("rel_lst", int'(dut.u_l.r_state), int'(ST_IDLE));
    @(negedge clk_50M);
    clr();
    count_win(P - 1);
    chk_win("r0", 0, 0, 0, 0);
    win("r1", 500, 0, 1249, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
